// File: rtl/approach_queue.sv
// approach_queue: vehicle queue at one traffic light approach.
// Counts arrivals, requests the light, releases vehicles at a fixed gap while
// green, and conditions the crossing sensor into a blocked signal with a hold.
// Ports: clock, reset (sync, active-high); arrive, crossing_busy, active, green in;
// request, blocked (registered), depart, overflow (pulses), queue_count, queue_full out.
// Optional: APPROACH_QUEUE_STATS_EN adds served_count and dropped_count outputs.
module approach_queue #(
    parameter int QUEUE_DEPTH  = 15,
    parameter int QW           = 4,
    parameter int RELEASE_GAP  = 3,
    parameter int CLEAR_CYCLES = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          arrive,
    input  logic          crossing_busy,
    input  logic          active,
    input  logic          green,
    output logic          request,
    output logic          blocked,
    output logic          depart,
    output logic [QW-1:0] queue_count,
    output logic          queue_full,
    output logic          overflow
`ifdef APPROACH_QUEUE_STATS_EN
    ,
    output logic [15:0]   served_count,
    output logic [15:0]   dropped_count
`endif
);
    localparam int GW = $clog2(RELEASE_GAP + 1);
    localparam int HW = $clog2(CLEAR_CYCLES + 2);

    typedef enum logic [1:0] {IDLE, CALL, WAIT, GO} state_t;

    state_t        state, state_next;
    logic [QW-1:0] count_next;
    logic [GW-1:0] gap, gap_next;
    logic [HW-1:0] hold;
    logic          accept;

    assign queue_full = queue_count == QW'(QUEUE_DEPTH);
    // Both pulses are suppressed while reset is asserted so the reset cycle is quiet.
    assign depart     = !reset && state == GO && green && queue_count != '0 && gap == '0;
    assign overflow   = !reset && arrive && queue_full && !depart;
    assign accept     = arrive && !overflow;

    always_comb begin
        count_next = queue_count;
        if (accept && !depart)
            count_next = queue_count + QW'(1);
        else if (!accept && depart)
            count_next = queue_count - QW'(1);
        gap_next = state != GO ? '0 : depart ? GW'(RELEASE_GAP - 1) : gap != '0 ? gap - GW'(1) : '0;
        state_next = state;
        case (state)
            IDLE:    if (arrive || queue_count != '0) state_next = CALL;
            CALL:    if (active) state_next = WAIT;
            WAIT:    if (green) state_next = GO; else if (!active) state_next = CALL;
            GO:      if (!green) state_next = count_next != '0 ? CALL : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            queue_count <= '0;
            gap         <= '0;
            hold        <= '0;
            request     <= 1'b0;
            blocked     <= 1'b0;
        end else begin
            state       <= state_next;
            queue_count <= count_next;
            gap         <= gap_next;
            hold        <= crossing_busy ? HW'(CLEAR_CYCLES) : hold != '0 ? hold - HW'(1) : '0;
            request     <= state_next == CALL;
            // hold counts down the clearance after the sensor drops; blocked trails it by a cycle.
            blocked     <= crossing_busy || hold != '0;
        end
    end

`ifdef APPROACH_QUEUE_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            served_count  <= '0;
            dropped_count <= '0;
        end else begin
            served_count <= served_count + 16'(depart);
            if (overflow && dropped_count != 16'hFFFF)
                dropped_count <= dropped_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_approach_queue.sv
// tb_approach_queue: self-checking bench for approach_queue (vector table,
// directed corner sequences, randomized run against a behavioural model).
module tb_approach_queue;
    localparam int DEPTH = 15, GAP = 3, CLR = 4;
    localparam int M_IDLE = 0, M_CALL = 1, M_WAIT = 2, M_GO = 3;

    logic clock = 1'b0, reset = 1'b1, arrive = 1'b0, crossing_busy = 1'b0, active = 1'b0, green = 1'b0;
    logic request, blocked, depart, queue_full, overflow;
    logic [3:0] queue_count;
`ifdef APPROACH_QUEUE_STATS_EN
    logic [15:0] served_count, dropped_count;
`endif

    typedef struct {
        int a, b, act, g, req, blk, dep, cnt;
    } vec_t;
    vec_t tbl [20];

    int checks = 0, errors = 0;
    int m_mode, m_cnt, m_cyc = 0, m_last_dep, m_last_busy, m_served, m_dropped;
    int e_dep, e_ovf;
    logic r_act = 1'b0, r_green = 1'b0;

    approach_queue dut (
        .clock(clock), .reset(reset), .arrive(arrive), .crossing_busy(crossing_busy),
        .active(active), .green(green), .request(request), .blocked(blocked),
        .depart(depart), .queue_count(queue_count), .queue_full(queue_full), .overflow(overflow)
`ifdef APPROACH_QUEUE_STATS_EN
        , .served_count(served_count), .dropped_count(dropped_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", n, a, e, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_cnt = 0; m_last_dep = -1000; m_last_busy = -1000;
        m_served = 0; m_dropped = 0;
    endtask

    task automatic drive_check(input logic a, input logic b, input logic act, input logic g);
        int since;
        arrive = a; crossing_busy = b; active = act; green = g;
        #2;
        e_dep = (m_mode == M_GO && g && m_cnt != 0 && m_cyc - m_last_dep >= GAP) ? 1 : 0;
        e_ovf = (a && m_cnt == DEPTH && e_dep == 0) ? 1 : 0;
        since = m_cyc - m_last_busy;
        chk("request", 32'(request), (m_mode == M_CALL) ? 1 : 0);
        chk("blocked", 32'(blocked), (since >= 1 && since <= CLR + 1) ? 1 : 0);
        chk("depart", 32'(depart), e_dep);
        chk("overflow", 32'(overflow), e_ovf);
        chk("queue_count", 32'(queue_count), m_cnt);
        chk("queue_full", 32'(queue_full), (m_cnt == DEPTH) ? 1 : 0);
`ifdef APPROACH_QUEUE_STATS_EN
        chk("served_count", 32'(served_count), m_served);
        chk("dropped_count", 32'(dropped_count), m_dropped);
`endif
    endtask

    task automatic advance();
        int nc;
        @(posedge clock);
        nc = m_cnt + ((arrive && e_ovf == 0) ? 1 : 0) - e_dep;
        if (m_mode != M_GO) m_last_dep = -1000;
        if (e_dep != 0) m_last_dep = m_cyc;
        if (crossing_busy) m_last_busy = m_cyc;
        m_served = (m_served + e_dep) % 65536;
        if (e_ovf != 0 && m_dropped < 65535) m_dropped++;
        case (m_mode)
            M_IDLE: if (arrive || m_cnt != 0) m_mode = M_CALL;
            M_CALL: if (active) m_mode = M_WAIT;
            M_WAIT: if (green) m_mode = M_GO; else if (!active) m_mode = M_CALL;
            default: if (!green) m_mode = (nc != 0) ? M_CALL : M_IDLE;
        endcase
        m_cnt = nc;
        m_cyc++;
        @(negedge clock);
    endtask

    task automatic cyc(input logic a, input logic b, input logic act, input logic g);
        drive_check(a, b, act, g);
        advance();
    endtask

    task automatic do_reset(input logic g);
        reset = 1'b1; arrive = 1'b0; crossing_busy = 1'b0; active = g; green = g;
        #2;
        chk("reset_depart", 32'(depart), 0);
        chk("reset_overflow", 32'(overflow), 0);
        @(posedge clock);
        model_reset();
        m_cyc++;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1,0,0,0, 0,0,0,0};
        tbl[1]  = '{0,0,0,0, 1,0,0,1};
        tbl[2]  = '{0,0,0,0, 1,0,0,1};
        tbl[3]  = '{0,0,1,0, 1,0,0,1};
        tbl[4]  = '{0,0,1,0, 0,0,0,1};
        tbl[5]  = '{0,0,1,1, 0,0,0,1};
        tbl[6]  = '{0,0,1,1, 0,0,1,1};
        tbl[7]  = '{0,0,1,1, 0,0,0,0};
        tbl[8]  = '{0,0,0,0, 0,0,0,0};
        tbl[9]  = '{0,0,0,0, 0,0,0,0};
        tbl[10] = '{0,1,0,0, 0,0,0,0};
        tbl[11] = '{0,1,0,0, 0,1,0,0};
        tbl[12] = '{0,1,0,0, 0,1,0,0};
        tbl[13] = '{0,0,0,0, 0,1,0,0};
        tbl[14] = '{1,0,0,0, 0,1,0,0};
        tbl[15] = '{0,0,0,0, 1,1,0,1};
        tbl[16] = '{0,0,0,0, 1,1,0,1};
        tbl[17] = '{0,0,0,0, 1,1,0,1};
        tbl[18] = '{0,0,0,0, 1,0,0,1};
        tbl[19] = '{0,0,0,0, 1,0,0,1};

        @(negedge clock);
        do_reset(1'b0);
        #1;
        chk("reset_request", 32'(request), 0);
        chk("reset_blocked", 32'(blocked), 0);
        chk("reset_count", 32'(queue_count), 0);
        chk("reset_full", 32'(queue_full), 0);

        for (int i = 0; i < 20; i++) begin
            drive_check(tbl[i].a[0], tbl[i].b[0], tbl[i].act[0], tbl[i].g[0]);
            chk($sformatf("tbl%0d_request", i), 32'(request), tbl[i].req);
            chk($sformatf("tbl%0d_blocked", i), 32'(blocked), tbl[i].blk);
            chk($sformatf("tbl%0d_depart", i), 32'(depart), tbl[i].dep);
            chk($sformatf("tbl%0d_count", i), 32'(queue_count), tbl[i].cnt);
            advance();
        end

        // Release gap: three queued vehicles leave at g, g+3, g+6; GO holds while green.
        do_reset(1'b0);
        repeat (3) cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);
        for (int k = 0; k < 7; k++) begin
            drive_check(0, 0, 1, 1);
            chk($sformatf("gap_depart%0d", k), 32'(depart), (k % 3 == 0) ? 1 : 0);
            chk($sformatf("gap_count%0d", k), 32'(queue_count), 3 - (k + 2) / 3);
            advance();
        end
        repeat (3) cyc(0, 0, 1, 1);
        drive_check(0, 0, 1, 1);
        chk("gap_empty_request", 32'(request), 0);
        chk("gap_empty_count", 32'(queue_count), 0);
        advance();
        repeat (2) cyc(0, 0, 0, 0);

        // Green drops right after the first depart with two queued: back to calling.
        do_reset(1'b0);
        repeat (2) cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);
        drive_check(0, 0, 1, 1);
        chk("drop_first_depart", 32'(depart), 1);
        advance();
        drive_check(0, 0, 0, 0);
        chk("drop_no_depart", 32'(depart), 0);
        advance();
        drive_check(0, 0, 0, 0);
        chk("drop_request", 32'(request), 1);
        chk("drop_count", 32'(queue_count), 1);
        advance();

        // Fill to capacity, overflow, then arrive together with depart.
        do_reset(1'b0);
        repeat (15) cyc(1, 0, 0, 0);
        drive_check(1, 0, 0, 0);
        chk("full_overflow", 32'(overflow), 1);
        chk("full_count", 32'(queue_count), 15);
        chk("full_flag", 32'(queue_full), 1);
        advance();
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);
        drive_check(1, 0, 1, 1);
        chk("full_swap_depart", 32'(depart), 1);
        chk("full_swap_overflow", 32'(overflow), 0);
        advance();
        drive_check(0, 0, 0, 0);
        chk("full_swap_count", 32'(queue_count), 15);
        advance();

        // Reset while in GO with five queued and a depart otherwise due.
        do_reset(1'b0);
        repeat (5) cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);
        do_reset(1'b1);
        drive_check(0, 0, 0, 0);
        chk("go_reset_count", 32'(queue_count), 0);
        chk("go_reset_request", 32'(request), 0);
        chk("go_reset_depart", 32'(depart), 0);
        chk("go_reset_blocked", 32'(blocked), 0);
`ifdef APPROACH_QUEUE_STATS_EN
        chk("go_reset_served", 32'(served_count), 0);
`endif
        advance();

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(599) == 0) do_reset(1'b0);
            if ($urandom_range(7) == 0) r_act = ~r_act;
            if ($urandom_range(5) == 0) r_green = ~r_green;
            cyc((n < 2000) ? ($urandom_range(1) == 0) : ($urandom_range(3) == 0),
                $urandom_range(5) == 0, r_act, r_green);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
